io_rgt_bscan_seq: RTL

Boundary-scan sequencer for the right-bottom IO column (8 IO tiles, 13 pads, one serial `sdi`→`sdo` chain).
- Accepts scan commands from the JTAG/config controller and drives the chain's `bs_en`, `hold`, `shift`, `update` and `hiz_b` controls with exact cycle sequencing.
- Serialises a parallel write vector into the chain and collects the chain's serial output into a parallel read vector.
- Sits between the TAP instruction decoder and the column's `io_col4` tiles; clocked by the column's `tclk`.

---
 rtl/io_rgt_bscan_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/io_rgt_bscan_seq.sv
// Boundary-scan sequencer for the right-bottom IO column chain.
// Serialises a command's write vector into the chain and collects the chain output into rdata.
`timescale 1ns/1ps
module io_rgt_bscan_seq #(
  parameter int unsigned CHAIN_LEN = 39,
  parameter int unsigned CW        = $clog2(CHAIN_LEN)
) (
  input  logic                 tclk,
  input  logic                 reset_b,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_wdata,
  output logic                 cmd_ready,
  input  logic                 abort,
  output logic                 done,
  output logic                 aborted,
  output logic [CHAIN_LEN-1:0] rdata,
  output logic                 sdi,
  input  logic                 sdo,
  output logic                 bs_en,
  output logic                 hold,
  output logic                 shift,
  output logic                 update,
  output logic                 hiz_b
);

  localparam logic [1:0] OP_SCAN    = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_HIZ     = 2'b10;
  localparam logic [1:0] OP_RELEASE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SHIFT   = 3'd2,
    S_UPDATE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [CHAIN_LEN-1:0] r_sr, w_sr_nxt;
  logic [CHAIN_LEN-1:0] r_rdata, w_rdata_nxt;
  logic r_ready, w_ready_nxt;
  logic r_done, w_done_nxt;
  logic r_aborted, w_aborted_nxt;
  logic r_sdi, w_sdi_nxt;
  logic r_bs_en, w_bs_en_nxt;
  logic r_hold, w_hold_nxt;
  logic r_shift, w_shift_nxt;
  logic r_update, w_update_nxt;
  logic r_hiz_b, w_hiz_b_nxt;
  logic w_last;

  assign w_last = (r_cnt == CW'(CHAIN_LEN - 1));

  // Next state plus next value of every registered output; sdi is pre-computed so it lines up with shift
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sr_nxt      = r_sr;
    w_rdata_nxt   = r_rdata;
    w_bs_en_nxt   = r_bs_en;
    w_hiz_b_nxt   = r_hiz_b;
    w_ready_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    w_sdi_nxt     = 1'b0;
    w_hold_nxt    = 1'b0;
    w_shift_nxt   = 1'b0;
    w_update_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (cmd_valid) begin
          w_ready_nxt = 1'b0;
          w_sr_nxt    = cmd_wdata;
          w_cnt_nxt   = '0;
          case (cmd_op)
            OP_SCAN: begin
              w_state_nxt = S_CAPTURE;
              w_bs_en_nxt = 1'b1;
              w_hold_nxt  = 1'b1;
            end
            OP_LOAD: begin
              w_state_nxt = S_SHIFT;
              w_bs_en_nxt = 1'b1;
              w_hold_nxt  = 1'b1;
              w_shift_nxt = 1'b1;
              w_sdi_nxt   = cmd_wdata[0];
            end
            OP_HIZ: begin
              w_state_nxt = S_DONE;
              w_hiz_b_nxt = 1'b0;
              w_done_nxt  = 1'b1;
            end
            OP_RELEASE: begin
              w_state_nxt = S_DONE;
              w_bs_en_nxt = 1'b0;
              w_hiz_b_nxt = 1'b1;
              w_done_nxt  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_SHIFT;
        w_hold_nxt  = 1'b1;
        w_shift_nxt = 1'b1;
        w_sdi_nxt   = r_sr[0];
      end
      S_SHIFT: begin
        w_sr_nxt           = {1'b0, r_sr[CHAIN_LEN-1:1]};
        w_rdata_nxt[r_cnt] = sdo;
        if (abort) begin
          w_state_nxt   = S_DONE;
          w_done_nxt    = 1'b1;
          w_aborted_nxt = 1'b1;
        end else if (w_last) begin
          w_state_nxt  = S_UPDATE;
          w_update_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_hold_nxt  = 1'b1;
          w_shift_nxt = 1'b1;
          w_sdi_nxt   = r_sr[1];
        end
      end
      S_UPDATE: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge tclk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_sdi     <= 1'b0;
      r_bs_en   <= 1'b0;
      r_hold    <= 1'b0;
      r_shift   <= 1'b0;
      r_update  <= 1'b0;
      r_hiz_b   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sr      <= w_sr_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ready   <= w_ready_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_sdi     <= w_sdi_nxt;
      r_bs_en   <= w_bs_en_nxt;
      r_hold    <= w_hold_nxt;
      r_shift   <= w_shift_nxt;
      r_update  <= w_update_nxt;
      r_hiz_b   <= w_hiz_b_nxt;
    end
  end

  assign cmd_ready = r_ready;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign rdata     = r_rdata;
  assign sdi       = r_sdi;
  assign bs_en     = r_bs_en;
  assign hold      = r_hold;
  assign shift     = r_shift;
  assign update    = r_update;
  assign hiz_b     = r_hiz_b;

endmodule
